// File: rtl/sram_burst_pkg.sv
// Shared types and SRAM opcode constants for the SRAM burst initiator.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_RD = 2'd1,
    RUN_WR = 2'd2
  } state_t;

  localparam logic SRAM_OP_READ  = 1'b1;
  localparam logic SRAM_OP_WRITE = 1'b0;

endpackage

// File: rtl/sram_rd_skid.sv
// Single-entry read-data holding register; a new capture wins over a drain
// in the same cycle, so the beat stays valid and ordering is preserved.
module sram_rd_skid #(
  parameter int EleLen = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture,
  input  logic [EleLen-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [EleLen-1:0] o_data
);

  logic              r_valid;
  logic [EleLen-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/sram_burst_initiator.sv
// Burst master for the single-port SRAM element array: one command at a time,
// streaming write data in or read data out. Optional SRAM_BURST_STALL_CNT_EN
// adds a saturating stall_cycles counter output.
module sram_burst_initiator
  import sram_burst_pkg::*;
#(
  parameter int EleLen      = 32,
  parameter int EleIdxWidth = 10,
  parameter int LenWidth    = EleIdxWidth + 1
) (
`ifdef SRAM_BURST_STALL_CNT_EN
  output logic [31:0]            stall_cycles,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_read,
  input  logic [EleIdxWidth-1:0] cmd_addr,
  input  logic [LenWidth-1:0]    cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [EleLen-1:0]      wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [EleLen-1:0]      rd_data,
  output logic                   done,
  output logic                   sram_valid,
  output logic                   sram_read_or_write,
  output logic [EleIdxWidth-1:0] sram_addr,
  output logic [EleLen-1:0]      sram_write_ele,
  input  logic                   sram_ready,
  input  logic [EleLen-1:0]      sram_read_ele,
  output logic [1:0]             dbg_state
);

  // Every interface transfers exactly on a cycle where valid && ready are both
  // high at the clock edge; valid never depends on ready of the same channel
  // except the read path, which only requests when the skid slot can take it.

  state_t                 r_state;
  state_t                 w_next_state;
  logic [EleIdxWidth-1:0] r_cur_addr;
  logic [LenWidth-1:0]    r_remaining;
  logic                   r_done;
  logic [EleIdxWidth-1:0] r_addr_hold;
  logic [EleLen-1:0]      r_wdata_hold;
  logic                   r_rw_hold;
  logic                   w_cmd_accept;
  logic                   w_retire;
  logic                   w_rd_capture;
  logic                   w_last_beat;

  assign w_last_beat = (r_remaining == LenWidth'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Reset gates every request output so an abandoned burst issues nothing.
  always_comb begin
    w_next_state       = r_state;
    w_cmd_accept       = 1'b0;
    w_retire           = 1'b0;
    w_rd_capture       = 1'b0;
    cmd_ready          = 1'b0;
    wr_ready           = 1'b0;
    sram_valid         = 1'b0;
    sram_read_or_write = r_rw_hold;
    sram_addr          = r_addr_hold;
    sram_write_ele     = r_wdata_hold;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            w_cmd_accept = 1'b1;
            if (cmd_len != '0) w_next_state = cmd_read ? RUN_RD : RUN_WR;
          end
        end
        RUN_WR: begin
          sram_valid         = wr_valid;
          sram_read_or_write = SRAM_OP_WRITE;
          sram_addr          = r_cur_addr;
          sram_write_ele     = wr_data;
          wr_ready           = sram_ready;
          w_retire           = wr_valid && sram_ready;
          if (w_retire && w_last_beat) w_next_state = IDLE;
        end
        RUN_RD: begin
          sram_valid         = !rd_valid || rd_ready;
          sram_read_or_write = SRAM_OP_READ;
          sram_addr          = r_cur_addr;
          w_retire           = sram_valid && sram_ready;
          w_rd_capture       = w_retire;
          if (w_retire && w_last_beat) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_done       <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_rw_hold    <= SRAM_OP_READ;
    end else begin
      r_done <= (w_cmd_accept && (cmd_len == '0)) || (w_retire && w_last_beat);
      if (w_cmd_accept) begin
        r_cur_addr  <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_retire) begin
        r_cur_addr  <= r_cur_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      // Snapshot what was driven so IDLE keeps presenting the last request.
      if (r_state != IDLE) begin
        r_addr_hold <= sram_addr;
        r_rw_hold   <= sram_read_or_write;
      end
      if (r_state == RUN_WR) r_wdata_hold <= wr_data;
    end
  end

  sram_rd_skid #(.EleLen(EleLen)) u_rd_skid (
    .clk      (clk),
    .rst      (rst),
    .i_capture(w_rd_capture),
    .i_data   (sram_read_ele),
    .i_ready  (rd_ready),
    .o_valid  (rd_valid),
    .o_data   (rd_data)
  );

`ifdef SRAM_BURST_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst || w_cmd_accept) begin
      r_stall_cycles <= '0;
    end else if ((r_state != IDLE) && sram_valid && !sram_ready &&
                 (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_burst_initiator.sv
// Directed self-checking bench for sram_burst_initiator with a small SRAM
// model (rom feeds reads, mem records writes).
module tb_sram_burst_initiator;
  import sram_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        sram_valid, sram_read_or_write, sram_ready;
  logic [9:0]  sram_addr;
  logic [31:0] sram_write_ele, sram_read_ele;
  logic [1:0]  dbg_state;
`ifdef SRAM_BURST_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [31:0] rom [0:1023];
  logic [31:0] mem [0:1023];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int acc_cnt = 0;
  int held_reads = 0;
  int done_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_burst_initiator dut (
`ifdef SRAM_BURST_STALL_CNT_EN
    .stall_cycles      (stall_cycles),
`endif
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_read          (cmd_read),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_data           (wr_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_data           (rd_data),
    .done              (done),
    .sram_valid        (sram_valid),
    .sram_read_or_write(sram_read_or_write),
    .sram_addr         (sram_addr),
    .sram_write_ele    (sram_write_ele),
    .sram_ready        (sram_ready),
    .sram_read_ele     (sram_read_ele),
    .dbg_state         (dbg_state)
  );

  assign sram_read_ele = rom[sram_addr];

  // SRAM model and scoreboard monitors.
  always @(posedge clk) begin
    if (sram_valid && sram_ready && !sram_read_or_write) mem[sram_addr] <= sram_write_ele;
    if (sram_valid && sram_ready) acc_cnt <= acc_cnt + 1;
    if (sram_valid && sram_ready && sram_read_or_write && rd_valid && !rd_ready)
      held_reads <= held_reads + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue_cmd(input logic rd, input logic [9:0] a, input logic [10:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_read = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; sram_ready = 0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%0h exp=0", cmd_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%0h exp=0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got=%0h exp=0", rd_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (sram_valid !== 1'b0) begin errors++; $display("FAIL rst_sram_valid got=%0h exp=0", sram_valid); end
    checks++; if (sram_read_or_write !== 1'b1) begin errors++; $display("FAIL rst_sram_rw got=%0h exp=1", sram_read_or_write); end
    checks++; if (sram_addr !== 10'h0) begin errors++; $display("FAIL rst_sram_addr got=%0h exp=0", sram_addr); end
    checks++; if (sram_write_ele !== 32'h0) begin errors++; $display("FAIL rst_sram_wele got=%0h exp=0", sram_write_ele); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%0h exp=0", wr_ready); end
`ifdef SRAM_BURST_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_cycles); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got=%0h exp=1", cmd_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL idle_state got=%0h exp=0", dbg_state); end
  endtask

  task automatic test_write();
    int d0;
    d0 = done_cnt;
    sram_ready = 1'b1;
    issue_cmd(1'b0, 10'h010, 11'd4);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'hA0 + i;
      #1;
      checks++; if (sram_valid !== 1'b1 || wr_ready !== 1'b1 || sram_read_or_write !== 1'b0)
        begin errors++; $display("FAIL wr_req%0d got=v%0h r%0h rw%0h exp=v1 r1 rw0", i, sram_valid, wr_ready, sram_read_or_write); end
      checks++; if (sram_addr !== 10'(10'h010 + i)) begin errors++; $display("FAIL wr_addr%0d got=%0h exp=%0h", i, sram_addr, 10'h010 + i); end
      checks++; if (sram_write_ele !== 32'hA0 + i) begin errors++; $display("FAIL wr_data%0d got=%0h exp=%0h", i, sram_write_ele, 32'hA0 + i); end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done got=%0h exp=1", done); end
    checks++; if (sram_valid !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL wr_idle_req got=v%0h r%0h exp=0", sram_valid, wr_ready); end
    checks++; if (sram_addr !== 10'h013 || sram_write_ele !== 32'hA3) begin errors++; $display("FAIL wr_hold got=%0h/%0h exp=13/a3", sram_addr, sram_write_ele); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got=%0h exp=1", cmd_ready); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_once got=%0h cnt=%0d exp=0 cnt=1", done, done_cnt - d0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[10'h010 + i] !== 32'hA0 + i) begin errors++; $display("FAIL wr_mem%0d got=%0h exp=%0h", i, mem[10'h010 + i], 32'hA0 + i); end
    end
  endtask

  task automatic test_read_wrap();
    logic [9:0] a;
    int base, d0;
    logic [9:0] exp_addr [4];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    for (int i = 0; i < 4; i++) begin
      rom[exp_addr[i]] = 32'hB0 + i;
      exp_q.push_back(32'hB0 + i);
    end
    base = got_q.size(); d0 = done_cnt;
    rd_ready = 1'b1; sram_ready = 1'b1;
    issue_cmd(1'b1, 10'h3FE, 11'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      a = sram_addr;
      checks++; if (sram_valid !== 1'b1 || sram_read_or_write !== 1'b1 || a !== exp_addr[i])
        begin errors++; $display("FAIL rd_addr%0d got=v%0h a%0h exp=v1 a%0h", i, sram_valid, a, exp_addr[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rd_done got=%0h exp=1", done); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (rd_valid !== 1'b0 || done_cnt - d0 != 1) begin errors++; $display("FAIL rd_drain got=v%0h cnt=%0d exp=v0 cnt=1", rd_valid, done_cnt - d0); end
    checks++; if (got_q.size() - base != 4) begin errors++; $display("FAIL rd_count got=%0d exp=4", got_q.size() - base); end
    for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
      checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rd_beat%0d got=%0h exp=%0h", i, got_q[base + i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_read_backpressure();
    int base, d0, h0;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      rom[10'h100 + i] = 32'hC0 + i;
      exp_q.push_back(32'hC0 + i);
    end
    base = got_q.size(); d0 = done_cnt; h0 = held_reads;
    rd_ready = 1'b1; sram_ready = 1'b1;
    issue_cmd(1'b1, 10'h100, 11'd3);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hC0) begin errors++; $display("FAIL bp_first got=v%0h d%0h exp=v1 dc0", rd_valid, rd_data); end
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hC0) begin errors++; $display("FAIL bp_hold got=v%0h d%0h exp=v1 dc0", rd_valid, rd_data); end
    checks++; if (held_reads - h0 > 1) begin errors++; $display("FAIL bp_held_reads got=%0d exp<=1", held_reads - h0); end
    rd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_done got=timeout exp=done"); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (got_q.size() - base != 3 || done_cnt - d0 != 1) begin errors++; $display("FAIL bp_count got=%0d/%0d exp=3/1", got_q.size() - base, done_cnt - d0); end
    for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
      checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got=%0h exp=%0h", i, got_q[base + i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_sram_stall();
    sram_ready = 1'b0;
    issue_cmd(1'b0, 10'h200, 11'd2);
    wr_valid = 1'b1; wr_data = 32'hD0;
`ifdef SRAM_BURST_STALL_CNT_EN
    #1;
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL stall_clear got=%0d exp=0", stall_cycles); end
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wr_ready !== 1'b0 || sram_valid !== 1'b1 || sram_addr !== 10'h200 || sram_write_ele !== 32'hD0)
        begin errors++; $display("FAIL stall_hold%0d got=r%0h v%0h a%0h d%0h exp=r0 v1 a200 dd0", i, wr_ready, sram_valid, sram_addr, sram_write_ele); end
      @(negedge clk);
    end
    sram_ready = 1'b1;
    @(negedge clk);
    wr_data = 32'hD1;
    #1;
    checks++; if (sram_addr !== 10'h201) begin errors++; $display("FAIL stall_addr2 got=%0h exp=201", sram_addr); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%0h exp=1", done); end
    checks++; if (mem[10'h200] !== 32'hD0 || mem[10'h201] !== 32'hD1) begin errors++; $display("FAIL stall_mem got=%0h/%0h exp=d0/d1", mem[10'h200], mem[10'h201]); end
`ifdef SRAM_BURST_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL stall_cycles got=%0d exp=3", stall_cycles); end
`endif
  endtask

  task automatic test_len_zero();
    int a0;
    a0 = acc_cnt;
    issue_cmd(1'b0, 10'h055, 11'd0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done got=%0h exp=1", done); end
    checks++; if (cmd_ready !== 1'b1 || sram_valid !== 1'b0) begin errors++; $display("FAIL len0_idle got=c%0h v%0h exp=c1 v0", cmd_ready, sram_valid); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || acc_cnt != a0) begin errors++; $display("FAIL len0_after got=d%0h acc%0d exp=d0 acc0", done, acc_cnt - a0); end
  endtask

  task automatic test_back_to_back();
    sram_ready = 1'b1;
    issue_cmd(1'b0, 10'h300, 11'd1);
    wr_valid = 1'b1; wr_data = 32'hE0;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 10'h301; cmd_len = 11'd1;
    @(negedge clk);
    wr_data = 32'hE1;
    #1;
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_overlap got=d%0h c%0h exp=d1 c1", done, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if (sram_valid !== 1'b1 || sram_addr !== 10'h301) begin errors++; $display("FAIL b2b_second got=v%0h a%0h exp=v1 a301", sram_valid, sram_addr); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%0h exp=1", done); end
    checks++; if (mem[10'h300] !== 32'hE0 || mem[10'h301] !== 32'hE1) begin errors++; $display("FAIL b2b_mem got=%0h/%0h exp=e0/e1", mem[10'h300], mem[10'h301]); end
  endtask

  task automatic test_reset_mid_burst();
    int d0, a0, base;
    for (int i = 0; i < 8; i++) rom[10'h080 + i] = 32'hF0 + i;
    rd_ready = 1'b1; sram_ready = 1'b1;
    issue_cmd(1'b1, 10'h080, 11'd8);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (sram_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_req got=%0h exp=0", sram_valid); end
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1;
    a0 = acc_cnt;
    checks++; if (dbg_state !== IDLE || rd_valid !== 1'b0 || sram_valid !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL mid_rst_state got=s%0h rv%0h v%0h d%0h exp=0 0 0 0", dbg_state, rd_valid, sram_valid, done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%0h exp=1", cmd_ready); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++; if (done_cnt != d0 || acc_cnt != a0) begin errors++; $display("FAIL mid_rst_quiet got=d%0d a%0d exp=0 0", done_cnt - d0, acc_cnt - a0); end
    base = got_q.size();
    issue_cmd(1'b1, 10'h085, 11'd1);
    @(negedge clk); @(negedge clk); #1;
    checks++; if (got_q.size() - base != 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL mid_rst_new got=%0d/%0d exp=1/1", got_q.size() - base, done_cnt - d0); end
    else begin
      checks++; if (got_q[base] !== 32'hF5) begin errors++; $display("FAIL mid_rst_data got=%0h exp=f5", got_q[base]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    test_reset();
    test_write();
    test_read_wrap();
    test_read_backpressure();
    test_sram_stall();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
